// File: rtl/eth_rxframe_ctrl_if.sv
// Descriptor-side and MAC-event bundle for the receive frame controller.
// The slave modport is the controller, the master modport drives header and
// end-of-frame events and consumes descriptors.
interface eth_rxframe_ctrl_if;
  logic        hdr_valid;
  logic [47:0] dst_mac;
  logic [15:0] len_type;
  logic        frame_done;
  logic [15:0] frame_bytes;
  logic        crc_err;
  logic        desc_valid;
  logic        desc_ready;
  logic [15:0] desc_len;
  logic [15:0] desc_type;
  logic        desc_bcast;

  modport master (
    output hdr_valid, dst_mac, len_type, frame_done, frame_bytes, crc_err,
    output desc_ready,
    input  desc_valid, desc_len, desc_type, desc_bcast
  );

  modport slave (
    input  hdr_valid, dst_mac, len_type, frame_done, frame_bytes, crc_err,
    input  desc_ready,
    output desc_valid, desc_len, desc_type, desc_bcast
  );
endinterface

// File: rtl/eth_rxframe_ctrl.sv
// Per-frame receive controller: address filter, length/CRC checks, descriptor
// queue with registered head, MAC receive gating and drop signalling.
// Optional feature macro: ETH_RXCTRL_STATS_EN adds saturating drop_cnt and
// accept_cnt output counters.
module eth_rxframe_ctrl #(
  parameter int DESC_DEPTH = 4,
  parameter int MIN_FL     = 64
) (
  input  logic        MRxClk,
  input  logic        Reset,
  input  logic [47:0] MAC,
  input  logic        r_Pro,
  input  logic        r_Bro,
  input  logic [15:0] MaxFL,
  input  logic        HugEn,
  eth_rxframe_ctrl_if.slave rx,
  output logic        rx_enable,
  output logic        drop_pulse
`ifdef ETH_RXCTRL_STATS_EN
  ,
  output logic [15:0] drop_cnt,
  output logic [15:0] accept_cnt
`endif
);

  localparam int PTR_W = $clog2(DESC_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0] MIN_FL_W = 16'(MIN_FL);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DESC_DEPTH);

  typedef enum logic [1:0] {WAIT_HDR, FILTER, WAIT_END, DISCARD} state_t;

  state_t      state, state_nxt;
  logic [47:0] lat_dst;
  logic [15:0] lat_type;

  logic        is_bcast, accept, len_bad;
  logic        push, pop, full, can_push;
  logic        drop_evt, latch_hdr, filter_ok;

  // Descriptor layout: {len[32:17], type[16:1], bcast[0]}
  logic [32:0]      mem [DESC_DEPTH];
  logic [32:0]      push_data, head_nxt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  assign is_bcast  = (lat_dst == 48'hFFFF_FFFF_FFFF);
  // Multicast needs no separate term: it only matches via r_Pro.
  assign accept    = r_Pro | (lat_dst == MAC) | (is_bcast & ~r_Bro);
  assign len_bad   = rx.crc_err | (rx.frame_bytes < MIN_FL_W) |
                     (~HugEn & (rx.frame_bytes > MaxFL));
  assign pop       = rx.desc_valid & rx.desc_ready;
  assign full      = (cnt == DEPTH_C);
  assign can_push  = ~full | pop;
  assign push_data = {rx.frame_bytes, lat_type, is_bcast};
  // In FILTER the filter decision of this very cycle governs a frame_done.
  assign filter_ok = (state == WAIT_END) | accept;

  // FSM state register
  always_ff @(posedge MRxClk) begin
    if (Reset) state <= WAIT_HDR;
    else       state <= state_nxt;
  end

  // Next-state, push and drop decisions
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    drop_evt  = 1'b0;
    latch_hdr = 1'b0;
    unique case (state)
      WAIT_HDR: begin
        if (rx.hdr_valid) begin
          latch_hdr = 1'b1;
          state_nxt = FILTER;
        end else if (rx.frame_done) begin
          drop_evt = 1'b1;
        end
      end
      FILTER, WAIT_END: begin
        if (rx.frame_done) begin
          state_nxt = WAIT_HDR;
          if (filter_ok && !len_bad && can_push) push = 1'b1;
          else                                   drop_evt = 1'b1;
        end else if (rx.hdr_valid) begin
          drop_evt  = 1'b1;
          latch_hdr = 1'b1;
          state_nxt = FILTER;
        end else if (state == FILTER) begin
          state_nxt = accept ? WAIT_END : DISCARD;
        end
      end
      DISCARD: begin
        if (rx.frame_done) begin
          drop_evt  = 1'b1;
          state_nxt = WAIT_HDR;
        end else if (rx.hdr_valid) begin
          drop_evt  = 1'b1;
          latch_hdr = 1'b1;
          state_nxt = FILTER;
        end
      end
      default: state_nxt = WAIT_HDR;
    endcase
  end

  // Header capture (data only, no reset needed)
  always_ff @(posedge MRxClk) begin
    if (latch_hdr) begin
      lat_dst  <= rx.dst_mac;
      lat_type <= rx.len_type;
    end
  end

  // Queue next-state: new head comes from the bypassed push when the queue
  // would otherwise be empty after this cycle's pop.
  always_comb begin
    cnt_nxt  = cnt + CNT_W'(push) - CNT_W'(pop);
    rd_nxt   = rd_ptr + PTR_W'(pop);
    head_nxt = (push && (cnt == CNT_W'(pop))) ? push_data : mem[rd_nxt];
  end

  // Queue storage write
  always_ff @(posedge MRxClk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Queue pointers, occupancy, registered head and receive gating
  always_ff @(posedge MRxClk) begin
    if (Reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      rx.desc_valid <= 1'b0;
      rx.desc_len   <= '0;
      rx.desc_type  <= '0;
      rx.desc_bcast <= 1'b0;
      rx_enable     <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr + PTR_W'(push);
      rd_ptr        <= rd_nxt;
      cnt           <= cnt_nxt;
      rx.desc_valid <= (cnt_nxt != '0);
      if ((cnt_nxt != '0) && (pop || !rx.desc_valid)) begin
        rx.desc_len   <= head_nxt[32:17];
        rx.desc_type  <= head_nxt[16:1];
        rx.desc_bcast <= head_nxt[0];
      end
      rx_enable     <= ~full;
    end
  end

  // Drop pulse lags the triggering event by one cycle
  always_ff @(posedge MRxClk) begin
    if (Reset) drop_pulse <= 1'b0;
    else       drop_pulse <= drop_evt;
  end

`ifdef ETH_RXCTRL_STATS_EN
  // Saturating drop and accept counters
  always_ff @(posedge MRxClk) begin
    if (Reset) begin
      drop_cnt   <= '0;
      accept_cnt <= '0;
    end else begin
      if (drop_pulse && (drop_cnt != 16'hFFFF))  drop_cnt   <= drop_cnt + 16'd1;
      if (push && (accept_cnt != 16'hFFFF))      accept_cnt <= accept_cnt + 16'd1;
    end
  end
`endif

endmodule
